// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the DE2 async SRAM controller.
// Optional input capture register: define SRAM_CTRL_IN_REG_EN.
package sram_ctrl_pkg;

  localparam int SRAM_AW     = 18;
  localparam int SRAM_DW     = 16;
  localparam int RD_WAIT_MAX = 7;
  localparam int WR_WAIT_MAX = 7;
  localparam int WAIT_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
`ifdef SRAM_CTRL_IN_REG_EN
    ST_RD_CAP,
`endif
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } sram_pins_t;

  // Strobe levels for the cycle spent in a given state; the pin flops load
  // this for the *next* state so pins change exactly on the state edge.
  function automatic sram_pins_t pins_for(sram_state_t s);
    sram_pins_t p;
    p = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
    case (s)
      ST_RD: begin
        p.ce_n = 1'b0;
        p.oe_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        p.ce_n  = 1'b0;
        p.dq_oe = 1'b1;
      end
      ST_WR_PULSE: begin
        p.ce_n  = 1'b0;
        p.we_n  = 1'b0;
        p.dq_oe = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sram_ctrl_io.sv
// Registered tri-state driver for the SRAM data bus, plus the optional
// pad-side input register (SRAM_CTRL_IN_REG_EN).
module sram_io
  import sram_ctrl_pkg::*;
#(
  parameter int DW = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dq_oe_d,
  input  logic          load,
  input  logic [DW-1:0] wdata,
`ifdef SRAM_CTRL_IN_REG_EN
  input  logic          cap,
`endif
  output logic [DW-1:0] din,
  inout  wire  [DW-1:0] dq
);

  logic          dq_oe;
  logic [DW-1:0] dout;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_oe <= 1'b0;
      dout  <= '0;
    end else begin
      dq_oe <= dq_oe_d;
      if (load) dout <= wdata;
    end
  end

  assign dq = dq_oe ? dout : 'z;

`ifdef SRAM_CTRL_IN_REG_EN
  logic [DW-1:0] in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else if (cap) in_q <= dq;
  end

  assign din = in_q;
`else
  assign din = dq;
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Single-port valid/ready controller for the DE2 256K x 16 async SRAM.
// Define SRAM_CTRL_IN_REG_EN to add an input capture stage (RD_CAP).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW      = SRAM_AW,
  parameter int DW      = SRAM_DW,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 0
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic [AW-1:0]   sram_addr,
  inout  wire  [DW-1:0]   sram_dq,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic [DW/8-1:0] sram_be_n
);

  localparam int BW = DW / 8;
  localparam logic [WAIT_W-1:0] RD_LAST = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_LAST = WAIT_W'(WR_WAIT);

  if (RD_WAIT < 0 || RD_WAIT > RD_WAIT_MAX) begin : g_rd_wait_range
    $error("sram_ctrl: RD_WAIT out of range");
  end
  if (WR_WAIT < 0 || WR_WAIT > WR_WAIT_MAX) begin : g_wr_wait_range
    $error("sram_ctrl: WR_WAIT out of range");
  end

  sram_state_t       state, state_d;
  logic [WAIT_W-1:0] cnt, cnt_d;
  logic [BW-1:0]     be_q, be_d;
  logic              accept;
  logic              rsp_load;
  sram_pins_t        pins_d;
  logic [DW-1:0]     din;

  assign req_ready = (state == ST_IDLE);

  // NOTE: every variable gets a default before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept   = 1'b0;
    rsp_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = req_write ? ST_WR_SETUP : ST_RD;
        end
      end
      ST_RD: begin
        if (cnt == RD_LAST) begin
`ifdef SRAM_CTRL_IN_REG_EN
          state_d = ST_RD_CAP;
`else
          state_d  = ST_IDLE;
          rsp_load = 1'b1;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef SRAM_CTRL_IN_REG_EN
      ST_RD_CAP: begin
        state_d  = ST_IDLE;
        rsp_load = 1'b1;
      end
`endif
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = '0;
      end
      ST_WR_PULSE: begin
        if (cnt == WR_LAST) state_d = ST_WR_HOLD;
        else                cnt_d   = cnt + 1'b1;
      end
      ST_WR_HOLD: state_d = ST_WR_HOLD == state ? ST_IDLE : state;
      default:    state_d = ST_IDLE;
    endcase
    be_d   = accept ? req_be : be_q;
    pins_d = pins_for(state_d);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      be_q      <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      be_q      <= be_d;
      if (accept) sram_addr <= req_addr;
      sram_ce_n <= pins_d.ce_n;
      sram_oe_n <= pins_d.oe_n;
      sram_we_n <= pins_d.we_n;
      // Byte lanes only assert while the chip is selected.
      sram_be_n <= pins_d.ce_n ? {BW{1'b1}} : ~be_d;
      rsp_valid <= rsp_load;
      if (rsp_load) rsp_rdata <= din;
    end
  end

  sram_io #(.DW(DW)) u_io (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .dq_oe_d (pins_d.dq_oe),
    .load    (accept & req_write),
    .wdata   (req_wdata),
`ifdef SRAM_CTRL_IN_REG_EN
    .cap     (state_d == ST_RD_CAP),
`endif
    .din     (din),
    .dq      (sram_dq)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default-timing instance driven from a vector
// table, plus a wait-state instance exercised back-to-back.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_IN_REG_EN
  localparam int CAP = 1;
`else
  localparam int CAP = 0;
`endif

  typedef struct packed {
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        chk;
    logic [15:0] rdata;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  // Instance 0: default timing
  logic        req_valid0, req_ready0, req_write0, rsp_valid0;
  logic [17:0] req_addr0, sram_addr0;
  logic [15:0] req_wdata0, rsp_rdata0;
  logic [1:0]  req_be0, be_n0;
  logic        ce_n0, oe_n0, we_n0;
  wire  [15:0] sram_dq0;

  // Instance 1: RD_WAIT=3, WR_WAIT=2
  logic        req_valid1, req_ready1, req_write1, rsp_valid1;
  logic [17:0] req_addr1, sram_addr1;
  logic [15:0] req_wdata1, rsp_rdata1;
  logic [1:0]  req_be1, be_n1;
  logic        ce_n1, oe_n1, we_n1;
  wire  [15:0] sram_dq1;

  sram_ctrl dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .sram_addr(sram_addr0), .sram_dq(sram_dq0), .sram_ce_n(ce_n0),
    .sram_oe_n(oe_n0), .sram_we_n(we_n0), .sram_be_n(be_n0)
  );

  sram_ctrl #(.RD_WAIT(3), .WR_WAIT(2)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .sram_addr(sram_addr1), .sram_dq(sram_dq1), .sram_ce_n(ce_n1),
    .sram_oe_n(oe_n1), .sram_we_n(we_n1), .sram_be_n(be_n1)
  );

  // Async SRAM models: drive on ce_n & oe_n low, byte-write while we_n low.
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  assign sram_dq0 = (!ce_n0 && !oe_n0) ? mem0[sram_addr0] : 16'bz;
  assign sram_dq1 = (!ce_n1 && !oe_n1) ? mem1[sram_addr1] : 16'bz;

  always @(posedge sys_clk) begin
    if (!ce_n0 && !we_n0) begin
      if (!be_n0[0]) mem0[sram_addr0][7:0]  <= sram_dq0[7:0];
      if (!be_n0[1]) mem0[sram_addr0][15:8] <= sram_dq0[15:8];
    end
    if (!ce_n1 && !we_n1) begin
      if (!be_n1[0]) mem1[sram_addr1][7:0]  <= sram_dq1[7:0];
      if (!be_n1[1]) mem1[sram_addr1][15:8] <= sram_dq1[15:8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [17:0] addr,
                              input logic [15:0] wdata, input logic [1:0] be,
                              input logic chk, input logic [15:0] rdata);
    vec_t v;
    v = '{wr: wr, addr: addr, wdata: wdata, be: be, chk: chk, rdata: rdata};
    return v;
  endfunction

  // Issue one request on instance 0 (entered and left at a negedge).
  task automatic run_vec(input vec_t v);
    int   lat;
    int   low_cnt;
    logic done;
    check("ready_before_req", req_ready0, 1);
    req_valid0 = 1'b1;
    req_write0 = v.wr;
    req_addr0  = v.addr;
    req_wdata0 = v.wdata;
    req_be0    = v.be;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid0 = 1'b0;
    lat     = 0;
    low_cnt = 0;
    done    = 1'b0;
    while (!done && lat < 30) begin
      if (v.wr) begin
        if (!ce_n0) check("wr_dq", sram_dq0, v.wdata);
        if (!oe_n0) check("wr_oe_n", oe_n0, 1);
        if (!we_n0) begin
          low_cnt++;
          check("wr_pulse_pins", {be_n0, sram_addr0}, {~v.be, v.addr});
        end
        if (req_ready0) done = 1'b1;
      end else begin
        if (!oe_n0) begin
          low_cnt++;
          check("rd_pins", {ce_n0, be_n0, sram_addr0}, {1'b0, ~v.be, v.addr});
          check("rd_dq_model", sram_dq0, mem0[v.addr]);
        end
        if (rsp_valid0) begin
          done = 1'b1;
          check("rd_ready_with_rsp", req_ready0, 1);
          if (v.chk) check("rd_data", rsp_rdata0, v.rdata);
        end else begin
          check("rd_busy_ready", req_ready0, 0);
        end
      end
      if (!done) begin
        @(posedge sys_clk);
        @(negedge sys_clk);
        lat++;
      end
    end
    if (v.wr) begin
      check("wr_latency", lat, 3);
      check("we_low_cycles", low_cnt, 1);
    end else begin
      check("rd_latency", lat, 1 + CAP);
      check("oe_low_cycles", low_cnt, 1);
      @(posedge sys_clk);
      @(negedge sys_clk);
      check("rsp_one_cycle", rsp_valid0, 0);
    end
    check("idle_pins", {ce_n0, oe_n0, we_n0, be_n0, dut0.u_io.dq_oe}, 6'b111110);
  endtask

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t seq [3];
    int   idx;
    logic hs;
    int   oe_run, we_run, busy, rsp_cnt, bad;
    int   oe_runs[$];
    int   we_runs[$];

    vecs[0]  = mk(1'b1, 18'h12345, 16'hBEEF, 2'b11, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b0, 18'h12345, 16'h0000, 2'b11, 1'b1, 16'hBEEF);
    vecs[2]  = mk(1'b1, 18'h00100, 16'h1234, 2'b11, 1'b0, 16'h0000);
    vecs[3]  = mk(1'b1, 18'h00100, 16'hAA55, 2'b01, 1'b0, 16'h0000);
    vecs[4]  = mk(1'b0, 18'h00100, 16'h0000, 2'b11, 1'b1, 16'h1255);
    vecs[5]  = mk(1'b1, 18'h3FFFF, 16'hA5A5, 2'b10, 1'b0, 16'h0000);
    vecs[6]  = mk(1'b0, 18'h3FFFF, 16'h0000, 2'b11, 1'b1, 16'hA500);
    vecs[7]  = mk(1'b1, 18'h00000, 16'h0F0F, 2'b11, 1'b0, 16'h0000);
    vecs[8]  = mk(1'b0, 18'h00000, 16'h0000, 2'b11, 1'b1, 16'h0F0F);
    vecs[9]  = mk(1'b0, 18'h12345, 16'h0000, 2'b00, 1'b0, 16'h0000);
    vecs[10] = mk(1'b0, 18'h3FFFF, 16'h0000, 2'b10, 1'b1, 16'hA500);

    for (int i = 0; i < 262144; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    mem1[18'h00ABC] = 16'h5A5A;

    sys_rst_n  = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;

    repeat (2) @(negedge sys_clk);
    check("rst_strobes", {ce_n0, oe_n0, we_n0, be_n0}, 5'b11111);
    check("rst_addr", sram_addr0, 0);
    check("rst_rsp", {rsp_valid0, rsp_rdata0}, 0);
    check("rst_dq_oe", dut0.u_io.dq_oe, 0);
    check("rst_ready", {req_ready0, req_ready1}, 2'b11);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset asserted while we_n is low
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 18'h00200;
    req_wdata0 = 16'h7777; req_be0 = 2'b11;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid0 = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("mid_we_low", we_n0, 0);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {we_n0, ce_n0, oe_n0, be_n0}, 5'b11111);
    check("mid_rst_dq_oe", dut0.u_io.dq_oe, 0);
    check("mid_rst_rsp", rsp_valid0, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("mid_rst_ready", req_ready0, 1);
    check("mid_rst_no_rsp", rsp_valid0, 0);

    // Back-to-back read/write/read on the wait-state instance
    seq[0] = mk(1'b0, 18'h00ABC, 16'h0000, 2'b11, 1'b1, 16'h5A5A);
    seq[1] = mk(1'b1, 18'h00DEF, 16'hC3C3, 2'b11, 1'b0, 16'h0000);
    seq[2] = mk(1'b0, 18'h00DEF, 16'h0000, 2'b11, 1'b1, 16'hC3C3);
    idx = 0; oe_run = 0; we_run = 0; busy = 0; rsp_cnt = 0; bad = 0;
    req_valid1 = 1'b1;
    req_write1 = seq[0].wr; req_addr1 = seq[0].addr;
    req_wdata1 = seq[0].wdata; req_be1 = seq[0].be;
    hs = req_valid1 && req_ready1;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      if (hs) begin
        idx++;
        if (idx < 3) begin
          req_write1 = seq[idx].wr; req_addr1 = seq[idx].addr;
          req_wdata1 = seq[idx].wdata; req_be1 = seq[idx].be;
        end else begin
          req_valid1 = 1'b0;
        end
      end
      if (!oe_n1) oe_run++;
      else if (oe_run != 0) begin oe_runs.push_back(oe_run); oe_run = 0; end
      if (!we_n1) begin
        we_run++;
        check("b2b_wr_dq", sram_dq1, 16'hC3C3);
      end else if (we_run != 0) begin
        we_runs.push_back(we_run); we_run = 0;
      end
      if (!oe_n1 && (dut1.u_io.dq_oe || sram_dq1 !== mem1[sram_addr1])) bad++;
      if (!req_ready1) busy++;
      if (rsp_valid1) begin
        rsp_cnt++;
        check("b2b_rdata", rsp_rdata1, (rsp_cnt == 1) ? 16'h5A5A : 16'hC3C3);
      end
      hs = req_valid1 && req_ready1;
    end
    check("b2b_oe_runs", oe_runs.size(), 2);
    if (oe_runs.size() == 2) check("b2b_oe_len", {oe_runs[0][7:0], oe_runs[1][7:0]}, 16'h0404);
    check("b2b_we_runs", we_runs.size(), 1);
    if (we_runs.size() == 1) check("b2b_we_len", we_runs[0], 3);
    check("b2b_busy_cycles", busy, 13 + 2 * CAP);
    check("b2b_rsp_count", rsp_cnt, 2);
    check("b2b_contention", bad, 0);
    check("b2b_all_accepted", idx, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller for the DE2 board's 256K x 16 asynchronous SRAM, sitting directly downstream of the framebuffer logic in the video system. It accepts one read or write request at a time on a valid/ready port and sequences `sram_addr`/`sram_dq`/`sram_ce_n`/`sram_oe_n`/`sram_we_n`/`sram_be_n` with registered, glitch-free pin timing. Read data returns on a one-cycle response pulse. The block runs entirely in the `sys_clk` domain.

## Interface
- `AW`, 18: SRAM word address width.
- `DW`, 16: SRAM data width; byte enables are `DW/8` wide.
- `RD_WAIT`, 0: extra `sys_clk` cycles `oe_n` is held low before capture (0..7).
- `WR_WAIT`, 0: extra `sys_clk` cycles `we_n` is held low (0..7).

Ports:
- `sys_clk`  in  1  system clock, 50 MHz nominal; the only clock.
- `sys_rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  DW  write data.
- `req_be`  in  DW/8  byte enables, active-high.
- `rsp_valid`  out  1  one-cycle pulse carrying read data.
- `rsp_rdata`  out  DW  read data, held until the next read response.
- `sram_addr`  out  AW  SRAM address.
- `sram_dq`  inout  DW  SRAM data; high-Z unless writing.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low.
- `sram_be_n`  out  DW/8  `{UB_N, LB_N}`, active-low.

## Operation
- States: IDLE, RD, RD_CAP (present only with the macro), WR_SETUP, WR_PULSE, WR_HOLD.
- `req_ready = (state == IDLE)`, decoded combinationally from the state register.
- Handshake: `req_valid & req_ready` at a rising edge. On handshake, register addr, wdata, be and write, then go to RD or WR_SETUP.
- While busy, upstream holds the request stable; it is not sampled.
- All SRAM pins are driven from flops. They are never combinational from `req_*`.
- RD:
  - `ce_n=0`, `oe_n=0`, `be_n=~be`, `dq` released.
  - Lasts `1+RD_WAIT` cycles.
  - On its last edge, `sram_dq` is captured into `rsp_rdata`, `rsp_valid` is set for one cycle, and the state goes to IDLE.
- WR_SETUP: 1 cycle. `ce_n=0`, `we_n=1`, `oe_n=1`, `dq` driven with wdata, `be_n=~be`.
- WR_PULSE: `1+WR_WAIT` cycles with `we_n=0`. Addr, data and be_n are held.
- WR_HOLD: 1 cycle with `we_n=1`, `dq` still driven. Then go to IDLE. Writes produce no response.
- IDLE pins: `ce_n=1`, `oe_n=1`, `we_n=1`, `be_n=2'b11`, `dq` high-Z. `sram_addr` keeps its last value.
- `req_be = 0`: the full cycle runs with `be_n=2'b11` (a no-op access). A read still returns `rsp_valid`, with undefined data.
- No address wrap or bounds logic: `AW` bits map directly to the pins.
- Reset mid-access: all outputs go to their reset values immediately, `dq` is released, no `rsp_valid` is issued, and the state returns to IDLE.
- Reset values: `sram_addr=0`, `ce_n=oe_n=we_n=1`, `be_n=2'b11`, `dq` high-Z, `rsp_valid=0`, `rsp_rdata=0`, state IDLE (so `req_ready=1`).

## Timing
- Acceptance edge E0 gives pins valid after E0.
- Read: `rsp_valid` is high in the cycle following edge `E(1+RD_WAIT)`. With defaults, that is 1 cycle after acceptance.
- Read throughput: one access per `2+RD_WAIT` cycles. `req_ready` rises in the same cycle as `rsp_valid`.
- Write: occupies `3+WR_WAIT` cycles after acceptance. With defaults, next acceptance is at E4.
- `dq` output enable turns on at WR_SETUP and off after WR_HOLD. It is never on while `oe_n=0`, so there is no bus contention.

## Configuration
- Macro `SRAM_CTRL_IN_REG_EN`.
- Defined:
  - On the last RD edge, `sram_dq` goes into an input register (intended for the IOB).
  - RD_CAP then forwards it to `rsp_rdata`/`rsp_valid`.
  - Read latency and throughput both increase by 1 cycle.
- Undefined: RD_CAP does not exist, and `rsp_rdata` captures directly from the pad.

## Structure
- Shared package `sram_ctrl_pkg`:
  - `sram_state_t` enum.
  - `SRAM_AW` = 18 and `SRAM_DW` = 16 defaults.
  - `RD_WAIT_MAX` / `WR_WAIT_MAX` = 7.
- One sub-module, `sram_io`: owns the registered output-enable and tri-state driver for `sram_dq`, plus the optional input register under the macro.
- The FSM, wait counter (3 bits) and request registers stay in `sram_ctrl`.

## Test plan
- Reset held low mid-write with `we_n=0` -> `we_n`, `ce_n`, `oe_n` = 1, `be_n`=2'b11 and `dq` high-Z immediately; `req_ready`=1 after release.
- Write addr 0x12345, data 0xBEEF, be=2'b11, defaults -> `we_n` low for exactly 1 cycle, `dq`=0xBEEF from WR_SETUP through WR_HOLD, next `req_ready` at E4.
- Read addr 0x12345 with the SRAM model returning 0xBEEF, defaults -> `rsp_valid` one cycle, `rsp_rdata`=0xBEEF, 1 cycle after acceptance (2 with `SRAM_CTRL_IN_REG_EN`).
- Write be=2'b01, data 0xAA55, to a word holding 0x1234 -> model holds 0x1255; `sram_be_n`=2'b10 during the pulse.
- `RD_WAIT=3`, `WR_WAIT=2`, back-to-back read/write/read with `req_valid` held -> `oe_n` low 4 cycles; `we_n` low 3 cycles; `dq` never driven while `oe_n=0`; `req_ready` low throughout each access.
- `req_be=0` read -> full RD cycle with `be_n=2'b11`, `rsp_valid` still pulses once.
